elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised successor to the plain enable-register wall.
- Carries a WIDTH-bit payload through STAGES cascaded skid-buffered pipeline stages using valid/ready handshakes.
- Provides per-stage back-pressure, a full-pipeline flush and an occupancy count.
- Used between out-of-order pipeline stages, e.g. rename→dispatch and issue→execute, where the downstream stage can stall.

Parameters:
- WIDTH, 223, payload bits per entry.
- STAGES, 1, number of cascaded skid stages (1..8); nominal latency in cycles.
- CLEAR_DATA, 1, 1 = reset zeroes all data registers; 0 = reset clears only valid state.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard every entry in the pipeline.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  this block can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload at the head of the last stage.
- occupancy  output  $clog2(2*STAGES+1)  total valid entries held.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset, and sampled on the rising edge of clk.
- Each stage holds a main register and a skid register. Stage states are EMPTY, ONE (main valid) and TWO (main and skid valid).
- Stage k handshake:
  - up_ready = (state != TWO), decoded from state registers only; no combinational path from out_ready to in_ready.
  - down_valid = (state != EMPTY); down_data = main.
  - push = up_valid & up_ready; pop = down_valid & down_ready.
- Stage transitions:
  - EMPTY + push → ONE, main <= up_data.
  - ONE + push & pop → ONE, main <= up_data.
  - ONE + push & !pop → TWO, skid <= up_data.
  - ONE + pop & !push → EMPTY.
  - ONE, no event → ONE, hold.
  - TWO + pop → ONE, main <= skid (push is impossible because up_ready = 0).
  - TWO, no pop → TWO, hold.
- Stage chaining: stage 0 connects to in_*; stage STAGES-1 connects to out_*; stage k down_* connects to stage k+1 up_*.
- Latency and throughput:
  - Latency is STAGES cycles from accepted input to out_valid when out_ready is held high.
  - Throughput is 1 per cycle under continuous out_ready.
- Ordering: entries leave in strict FIFO order. No duplication; no loss except through flush.
- Capacity: 2*STAGES. When full, in_ready = 0.
- occupancy: registered sum of valid bits across all stages, updated the same edge as the state change.
- flush:
  - Highest priority after reset.
  - Next edge: every stage goes to EMPTY and occupancy = 0.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle still completes downstream, since out_valid was already high.
  - Data registers are not cleared by flush.
- reset:
  - All stages EMPTY; out_valid = 0; occupancy = 0.
  - in_ready = 1 from the first cycle after reset.
  - out_data = 0 if CLEAR_DATA = 1, else undefined.
  - Reset mid-transfer drops all entries. Reset overrides flush.
- Boundary conditions:
  - in_valid while in_ready = 0 has no effect.
  - out_ready while out_valid = 0 has no effect.
  - in_data and out_ready are X-tolerant when their matching valid is low.

Optional Feature:
- Macro: ELASTIC_PIPE_REG_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cycles, 32 bits.
  - Increments on every cycle with out_valid & !out_ready and saturates at 32'hFFFF_FFFF.
  - Cleared only by reset, not by flush.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then STAGES=1, WIDTH=8: push 8'hA5 with out_ready=1 → out_valid=1 with out_data=8'hA5 one cycle later; occupancy sequence 1 then 0.
- STAGES=2, out_ready=0: push 0x01..0x05 → exactly 4 accepted; in_ready=0 after the 4th; occupancy=4. Raising out_ready drains 0x01..0x04 in order, one per cycle.
- Streaming 100 back-to-back words with out_ready toggling pseudo-randomly → output sequence equals input sequence; no in_ready/out_ready combinational loop.
- Full pipeline, flush asserted for one cycle together with in_valid=1 (data 0xEE) → next cycle out_valid=0 and occupancy=0; 0xEE never appears at the output.
- Reset asserted while occupancy=3 → next cycle out_valid=0, occupancy=0, in_ready=1; with CLEAR_DATA=1, out_data=0.
- With ELASTIC_PIPE_REG_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 10 cycles → stall_cycles=10; a flush leaves it at 10; reset clears it to 0.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Cascade of STAGES skid-buffered valid/ready register stages with flush and occupancy count.
// Optional stall counter output is enabled by defining ELASTIC_PIPE_REG_STALL_CNT_EN.
module elastic_pipe_reg #(
    parameter int WIDTH      = 223,
    parameter int STAGES     = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(2*STAGES+1)-1:0]      occupancy
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    ,
    output logic [31:0]                        stall_cycles
`endif
);

    localparam int OW = $clog2(2*STAGES+1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Handshake chain: index k is the upstream side of stage k, index k+1 its downstream side.
    logic [STAGES:0]            vld;
    logic [STAGES:0]            rdy;
    logic [STAGES:0][WIDTH-1:0] dat;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    assign out_valid   = vld[STAGES];
    assign out_data    = dat[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_state_t     state;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             push;
        logic             pop;

        // Ready depends only on this stage's own state, so out_ready never reaches in_ready.
        assign rdy[k]     = (state != TWO);
        assign vld[k+1]   = (state != EMPTY);
        assign dat[k+1]   = main_q;
        assign push       = vld[k] & rdy[k];
        assign pop        = vld[k+1] & rdy[k+1];

        // NOTE: state and payload use <= so each stage sees its neighbour's pre-edge value.
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= EMPTY;
                // NOTE: payload registers get a reset only when CLEAR_DATA is set; emptiness lives in state.
                if (CLEAR_DATA != 0) begin
                    main_q <= '0;
                    skid_q <= '0;
                end
            end else if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (push) begin
                            state  <= ONE;
                            main_q <= dat[k];
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_q <= dat[k];
                        end else if (push) begin
                            state  <= TWO;
                            skid_q <= dat[k];
                        end else if (pop) begin
                            state  <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            state  <= ONE;
                            main_q <= skid_q;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    // Internal stage-to-stage moves conserve the entry count, so only the ends change it.
    logic push_in;
    logic pop_out;

    assign push_in = in_valid & in_ready;
    assign pop_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OW'(push_in) - OW'(pop_out);
        end
    end

`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Drives a 1-stage and a 2-stage elastic_pipe_reg with shared stimulus and checks both
// against queue-based reference models.
module tb_elastic_pipe_reg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [1:0] a_occ;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [2:0] b_occ;
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    logic [31:0] a_stall, b_stall;
`endif

    elastic_pipe_reg #(.WIDTH(8), .STAGES(1), .CLEAR_DATA(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
        , .stall_cycles(a_stall)
`endif
    );

    elastic_pipe_reg #(.WIDTH(8), .STAGES(2), .CLEAR_DATA(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
        , .stall_cycles(b_stall)
`endif
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         a_pushes = 0;
    int         b_pushes = 0;
    int         a_stall_m = 0;
    int         b_stall_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check model invariants mid-cycle, then advance the models by the edge's handshakes.
    task automatic tick();
        logic       ap, bp, ao, bo, as_, bs, rs, fl;
        logic [7:0] d;
        @(negedge clk);
        check("a_occ", 32'(a_occ), 32'(qa.size()));
        check("b_occ", 32'(b_occ), 32'(qb.size()));
        if (qa.size() == 0) begin
            check("a_ready_empty", 32'(a_in_ready), 32'd1);
            check("a_valid_empty", 32'(a_out_valid), 32'd0);
        end else begin
            check("a_valid_nonempty", 32'(a_out_valid), 32'd1);
        end
        if (qa.size() == 2) check("a_ready_full", 32'(a_in_ready), 32'd0);
        if (qb.size() == 0) begin
            check("b_ready_empty", 32'(b_in_ready), 32'd1);
            check("b_valid_empty", 32'(b_out_valid), 32'd0);
        end
        if (qb.size() == 4) check("b_ready_full", 32'(b_in_ready), 32'd0);
        ap  = in_valid & a_in_ready;
        bp  = in_valid & b_in_ready;
        ao  = a_out_valid & out_ready;
        bo  = b_out_valid & out_ready;
        as_ = a_out_valid & ~out_ready;
        bs  = b_out_valid & ~out_ready;
        if (ao && qa.size() > 0) check("a_data", 32'(a_out_data), 32'(qa[0]));
        if (bo && qb.size() > 0) check("b_data", 32'(b_out_data), 32'(qb[0]));
        rs = reset;
        fl = flush;
        d  = in_data;
        @(posedge clk);
        #1;
        if (rs) begin
            qa.delete();
            qb.delete();
            a_stall_m = 0;
            b_stall_m = 0;
        end else begin
            if (as_) a_stall_m++;
            if (bs) b_stall_m++;
            if (fl) begin
                qa.delete();
                qb.delete();
            end else begin
                if (ao && qa.size() > 0) void'(qa.pop_front());
                if (bo && qb.size() > 0) void'(qb.pop_front());
                if (ap) begin qa.push_back(d); a_pushes++; end
                if (bp) begin qb.push_back(d); b_pushes++; end
            end
        end
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
        check("a_stall", a_stall, 32'(a_stall_m));
        check("b_stall", b_stall, 32'(b_stall_m));
`endif
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_a_ready", 32'(a_in_ready), 32'd1);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);

        // Single word: 1-stage latency 1, 2-stage latency 2.
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        check("lat_a_valid", 32'(a_out_valid), 32'd1);
        check("lat_a_data", 32'(a_out_data), 32'hA5);
        check("lat_a_occ1", 32'(a_occ), 32'd1);
        check("lat_b_valid0", 32'(b_out_valid), 32'd0);
        tick();
        check("lat_a_occ0", 32'(a_occ), 32'd0);
        check("lat_b_valid1", 32'(b_out_valid), 32'd1);
        check("lat_b_data", 32'(b_out_data), 32'hA5);
        tick();

        // Fill under back-pressure: capacity 2*STAGES.
        out_ready = 1'b0;
        a_pushes  = 0;
        b_pushes  = 0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'hxx;
        check("fill_b_accepted", 32'(b_pushes), 32'd4);
        check("fill_a_accepted", 32'(a_pushes), 32'd2);
        check("fill_b_ready", 32'(b_in_ready), 32'd0);
        check("fill_b_occ", 32'(b_occ), 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_b_valid", 32'(b_out_valid), 32'd1);
            check("drain_b_data", 32'(b_out_data), 32'(i));
            tick();
        end
        check("drain_b_occ", 32'(b_occ), 32'd0);

        // Streaming with random back-pressure.
        b_pushes = 0;
        for (int cyc = 0; cyc < 2000 && b_pushes < 100; cyc++) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        check("stream_count", 32'(b_pushes >= 100), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (qa.size() + qb.size()) > 0; i++) tick();
        check("stream_drained", 32'(b_occ), 32'd0);

        // Flush a full pipeline together with a push of 0xEE and a completing pop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10 && b_in_ready; i++) begin
            in_data = 8'($urandom_range(0, 8'hED));
            tick();
        end
        check("pre_flush_b_occ", 32'(b_occ), 32'd4);
        flush     = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_b_valid", 32'(b_out_valid), 32'd0);
        check("flush_b_occ", 32'(b_occ), 32'd0);
        check("flush_a_valid", 32'(a_out_valid), 32'd0);
        check("flush_b_ready", 32'(b_in_ready), 32'd1);
        repeat (3) tick();

        // Reset mid-transfer with three entries held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_b_occ", 32'(b_occ), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_b_valid2", 32'(b_out_valid), 32'd0);
        check("rst_b_occ", 32'(b_occ), 32'd0);
        check("rst_b_ready", 32'(b_in_ready), 32'd1);
        check("rst_b_data", 32'(b_out_data), 32'd0);
        check("rst_a_data", 32'(a_out_data), 32'd0);

`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5 && !b_out_valid; i++) tick();
        check("stall_wait_valid", 32'(b_out_valid), 32'd1);
        repeat (10) tick();
        check("stall_ten", b_stall, 32'd10);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_after_flush", b_stall, 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stall_after_reset", b_stall, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
